// File: rtl/cache_pkg.sv
// Shared cache geometry and miss-handling types for the I and D caches.
package cache_pkg;

   // Default line geometry, also used to size the cache data and tag arrays.
   localparam int unsigned CACHE_ADDR_W         = 16;
   localparam int unsigned CACHE_DATA_W         = 16;
   localparam int unsigned CACHE_WORDS_PER_LINE = 8;
   localparam int unsigned CACHE_WORD_BYTES     = 2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_t;

   // Number of byte-offset bits inside one cache line.
   function automatic int unsigned OFFSET_W(input int unsigned words_per_line,
                                            input int unsigned word_bytes);
      return $clog2(words_per_line * word_bytes);
   endfunction

endpackage

// File: rtl/fill_counter.sv
// Small up-counter with synchronous clear; tracks request and return progress of a fill.
module fill_counter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count
);

   // Clear wins over enable so a new fill always starts from zero.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: requests every word of the missing line, streams the
// returned words into the data array, then writes the tag and pulses done.
module cache_fill_fsm
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_W         = CACHE_ADDR_W,
   parameter int unsigned DATA_W         = CACHE_DATA_W,
   parameter int unsigned WORDS_PER_LINE = CACHE_WORDS_PER_LINE,
   parameter int unsigned WORD_BYTES     = CACHE_WORD_BYTES
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              miss_detected,
   input  logic [ADDR_W-1:0]                 miss_address,
   input  logic                              mem_ready,
   input  logic                              memory_data_valid,
   input  logic [DATA_W-1:0]                 memory_data,
   output logic                              mem_en,
   output logic [ADDR_W-1:0]                 mem_address,
   output logic                              fsm_busy,
   output logic                              write_data_array,
   output logic [$clog2(WORDS_PER_LINE)-1:0] fill_word_idx,
   output logic [DATA_W-1:0]                 fill_data,
   output logic                              write_tag_array,
   output logic                              fill_done
);

   localparam int unsigned IDX_W = $clog2(WORDS_PER_LINE);
   // One extra bit so a count of WORDS_PER_LINE (all words done) is representable.
   localparam int unsigned CNT_W = IDX_W + 1;
   localparam int unsigned OFF_W = OFFSET_W(WORDS_PER_LINE, WORD_BYTES);

   localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WORDS_PER_LINE);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORDS_PER_LINE - 1);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
   localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(WORD_BYTES);

   fill_state_t       state_q;
   logic [ADDR_W-1:0] base_q;
   logic [CNT_W-1:0]  req_cnt;
   logic [CNT_W-1:0]  rcv_cnt;

   logic start;
   logic in_fill;
   logic req_pending;
   logic req_fire;
   logic rcv_fire;
   logic last_word;

   // Decode per-cycle handshake events from registered state and inputs.
   always_comb begin
      in_fill     = (state_q == FILL);
      start       = (state_q == IDLE) && miss_detected;
      req_pending = in_fill && (req_cnt < CNT_FULL);
      req_fire    = req_pending && mem_ready;
      // Returns are only consumed in FILL and only until the line is complete.
      rcv_fire    = in_fill && memory_data_valid && (rcv_cnt < CNT_FULL);
      last_word   = rcv_fire && (rcv_cnt == CNT_LAST);
   end

   fill_counter #(
      .WIDTH(CNT_W)
   ) u_req_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (start),
      .enable(req_fire),
      .count (req_cnt)
   );

   fill_counter #(
      .WIDTH(CNT_W)
   ) u_rcv_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (start),
      .enable(rcv_fire),
      .count (rcv_cnt)
   );

   // Fill state and line base address; misses are ignored once a fill is running.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         base_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (miss_detected) begin
                  state_q <= FILL;
                  base_q  <= miss_address & ~OFF_MASK;
               end
            end
            FILL: begin
               if (last_word) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Memory request, array write and completion outputs.
   always_comb begin
      mem_en           = req_pending;
      mem_address      = base_q + ADDR_W'(req_cnt) * STRIDE;
      // Stall the pipeline already on the miss cycle itself.
      fsm_busy         = in_fill || start;
      write_data_array = rcv_fire;
      fill_word_idx    = rcv_fire ? rcv_cnt[IDX_W-1:0] : '0;
      fill_data        = rcv_fire ? memory_data : '0;
      write_tag_array  = last_word;
      fill_done        = last_word;
   end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Parametrised miss-handling engine for the Phase-2/3 pipelined WISC CPU caches. One instance sits in front of each cache (I and D).
- On a cache miss it issues one word read per line word to the shared multi-cycle main memory.
- It streams the returned words into the cache data array, then writes the tag, and pulses done.
- It tolerates any memory latency, gaps in returned data, and request back-pressure.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, memory word width in bits.
- WORDS_PER_LINE, 8, words per cache line; must be a power of 2 and at least 2.
- WORD_BYTES, 2, byte stride between consecutive words.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- miss_detected  in  1  cache miss this cycle.
- miss_address  in  ADDR_W  byte address of the missing access.
- mem_ready  in  1  memory accepts a request this cycle.
- memory_data_valid  in  1  memory_data holds a returned word.
- memory_data  in  DATA_W  returned word; arrives in request order.
- mem_en  out  1  read request valid.
- mem_address  out  ADDR_W  request byte address.
- fsm_busy  out  1  fill in progress; pipeline stalls while high.
- write_data_array  out  1  write fill_data into the line word at fill_word_idx.
- fill_word_idx  out  log2(WORDS_PER_LINE)  word index of the current data write.
- fill_data  out  DATA_W  word to write.
- write_tag_array  out  1  write the tag and set the valid bit for the line.
- fill_done  out  1  one-cycle pulse marking fill completion.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, both counters=0, base=0, all outputs 0. This holds even mid-fill. Outstanding memory returns after reset are ignored.
- States: IDLE, FILL.
- IDLE -> FILL: when miss_detected=1 at a clk edge.
  - Latch base = miss_address with the low log2(WORDS_PER_LINE*WORD_BYTES) bits zeroed.
  - Clear req_cnt and rcv_cnt.
- FILL request side:
  - mem_en = (req_cnt < WORDS_PER_LINE); mem_address = base + req_cnt*WORD_BYTES, truncated to ADDR_W.
  - req_cnt increments only when mem_en & mem_ready.
  - mem_en and mem_address are combinational from registered state; the first request appears the cycle after the miss edge.
- FILL return side: each cycle with memory_data_valid=1 and rcv_cnt < WORDS_PER_LINE:
  - write_data_array=1, fill_word_idx=rcv_cnt, fill_data=memory_data (same cycle, combinational).
  - rcv_cnt increments.
- Last word (rcv_cnt == WORDS_PER_LINE-1 with valid):
  - write_data_array, write_tag_array and fill_done are all 1 in that same cycle.
  - The next state is IDLE.
- fsm_busy = (state==FILL), and is also high in the IDLE cycle where miss_detected=1. The pipeline therefore stalls on the miss cycle itself.
- Ignored inputs:
  - miss_detected while in FILL.
  - memory_data_valid while in IDLE.
  - memory_data_valid once rcv_cnt has reached WORDS_PER_LINE.
- A return in the same cycle as an accepted request is legal; both counters update.
- Counter widths are log2(WORDS_PER_LINE)+1 bits, so a count of WORDS_PER_LINE is representable.
- Latency: with mem_ready tied to 1 and a fixed memory latency L, fill_done occurs WORDS_PER_LINE+L-1 cycles after the first request.
- Back-to-back misses: a miss asserted in the cycle after fill_done starts a new fill. No idle gap is required beyond the single IDLE cycle.

Decomposition:
- Shared package cache_pkg holds:
  - typedef enum fill_state_t {IDLE, FILL};
  - function clog2-based OFFSET_W(WORDS_PER_LINE, WORD_BYTES);
  - localparams for the default line geometry, also shared by the cache data/tag arrays.
- Sub-module: fill_counter, parametrised width, with clear, enable and count output. It is instantiated twice (request counter and receive counter).
- The FSM and output logic stay in cache_fill_fsm.

Test Plan:
- Basic fill: 8 words, mem_ready=1, memory model with L=4, miss_address=0x1234.
  - Expected requests: 0x1230, 0x1232, …, 0x123E on consecutive cycles.
  - Expected writes: idx 0..7 carry the model's data in order.
  - Expected completion: write_tag_array and fill_done together 11 cycles after the first request, then fsm_busy=0.
- Back-pressure: mem_ready toggled 1,0,0,1,…
  - mem_en stays high and mem_address holds while mem_ready=0.
  - Exactly 8 requests, no duplicate addresses, 8 data writes.
- Return gaps: memory_data_valid pulsed every third cycle.
  - rcv_cnt advances only on valid; fill_done arrives only on the 8th valid.
- Spurious inputs:
  - memory_data_valid=1 while IDLE -> write_data_array stays 0.
  - miss_detected=1 mid-fill with address 0x8000 -> base unchanged, no 0x8000 request.
- Reset mid-fill: rst_n low after 3 data words.
  - Next cycle: all outputs 0 and state IDLE.
  - A new miss at 0x0040 restarts from idx 0 with request 0x0040.
- Geometry: WORDS_PER_LINE=4, WORD_BYTES=2, miss_address=0xFFFE.
  - Base is 0xFFF8; requests are 0xFFF8, 0xFFFA, 0xFFFC, 0xFFFE.
  - fill_word_idx width is 2; done after 4 writes.
